pad_cfg_chain: RTL and testbench
================================

PAD_CFG_CHAIN -- requirements
Module: pad_cfg_chain

Interface
REQ-001 Parameter NUM_PADS, default 40, number of bidirectional pads controlled.
REQ-002 Parameter CFG_BITS, default 3, mode bits per pad (fixed at 3 for mode decoding below; wider values zero-extend decode).
REQ-003 Parameter RESET_MODE, default 3'b001, mode loaded into every pad at reset.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 cfg_sdi  input  1  serial configuration data in.
REQ-007 cfg_shift  input  1  shift enable for the shadow chain.
REQ-008 cfg_load  input  1  request to transfer shadow chain to active config.
REQ-009 cfg_sdo  output  1  serial data out, MSB of shadow chain.
REQ-010 cfg_ack  output  1  one-cycle pulse: load accepted.
REQ-011 cfg_err  output  1  one-cycle pulse: load rejected (wrong bit count).
REQ-012 core_out  input  NUM_PADS  output data from core logic.
REQ-013 core_oe  input  NUM_PADS  per-pad output enable from core (bidir mode only).
REQ-014 core_in  output  NUM_PADS  synchronised pad input to core.
REQ-015 pad_in  input  NUM_PADS  raw input from pad cells (asynchronous).
REQ-016 pad_out  output  NUM_PADS  data to pad cells.
REQ-017 pad_oe  output  NUM_PADS  output enable to pad cells, 1 = drive.

Function
REQ-018 Shadow chain SHALL be NUM_PADS*CFG_BITS flops; pad k config = shadow[k*CFG_BITS +: CFG_BITS].
REQ-019 cfg_shift=1 SHALL shift shadow left by one per cycle, cfg_sdi into bit 0; cfg_sdo = shadow MSB (combinational from flop).
REQ-020 A shift counter SHALL count shifts since last load/reset, saturating at 2**clog2(NUM_PADS*CFG_BITS+1)-1.
REQ-021 cfg_load=1 with cfg_shift=0 SHALL, if count == NUM_PADS*CFG_BITS, copy shadow to active config and pulse cfg_ack next cycle; otherwise leave active unchanged and pulse cfg_err next cycle.
REQ-022 Either load outcome SHALL clear the shift counter.
REQ-023 cfg_load and cfg_shift both high SHALL perform the shift only; load ignored, no ack/err.
REQ-024 cfg_load held high N cycles SHALL be evaluated every cycle (second cycle sees count 0 -> cfg_err unless NUM_PADS*CFG_BITS is 0).
REQ-025 Mode decode per pad from active config: 000 disabled (oe=0, out=0, core_in=0); 001 input (oe=0); 010 output (oe=1, out=core_out); 011 bidir (oe=core_oe, out=core_out); 100 drive 0 (oe=1, out=0); 101 drive 1 (oe=1, out=1); 110/111 treated as 000.
REQ-026 pad_out and pad_oe SHALL be registered: one-cycle latency from core_out/core_oe/active-config change.
REQ-027 core_in SHALL pass pad_in through a two-flop synchroniser then be masked to 0 unless mode is 001 or 011; latency two cycles from pad_in edge.
REQ-028 Mode mask on core_in SHALL be applied after the synchroniser, same cycle as active config.
REQ-029 New active config SHALL affect pad_out/pad_oe on the cycle after cfg_ack is asserted.

Reset
REQ-030 rst_n low SHALL asynchronously set shadow and active config of every pad to RESET_MODE, counter to 0, synchroniser flops to 0.
REQ-031 During/after reset: pad_oe=0, pad_out=0, core_in=0, cfg_ack=0, cfg_err=0, cfg_sdo=RESET_MODE MSB of top pad.
REQ-032 Reset mid-shift or mid-load SHALL discard partial chain contents; no ack/err pulse after release.

Verification
REQ-033 Reset release, NUM_PADS=4: pad_oe=4'b0000; drive pad_in=4'b1010 -> core_in=4'b1010 two cycles later.
REQ-034 Shift 12 bits giving pads 3..0 = 101,100,010,011, then load -> cfg_ack pulse; next cycle pad_oe={1,1,1,core_oe[0]}, pad_out={1,0,core_out[1],core_out[0]}, core_in[3:1]=0.
REQ-035 Shift 11 bits then load -> cfg_err pulse, active config unchanged, counter 0.
REQ-036 cfg_shift and cfg_load high together on 12th bit -> shift done, no ack/err; next cycle load alone -> cfg_ack.
REQ-037 Shift 13 bits then load -> cfg_err; cfg_sdo after 12 shifts equals first bit shifted in.
REQ-038 Assert rst_n low after 6 shifts -> all pads return to mode 001, pad_oe=0, subsequent 12-bit shift+load -> cfg_ack.

Source files
------------

// File: rtl/pad_cfg_chain.sv
// Serially configured pad controller: a shift-in shadow chain is committed to the
// active per-pad mode registers only when exactly NUM_PADS*CFG_BITS bits were shifted.
module pad_cfg_chain #(
    parameter int NUM_PADS = 40,
    parameter int CFG_BITS = 3,
    parameter logic [CFG_BITS-1:0] RESET_MODE = CFG_BITS'(3'b001)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_sdi,
    input  logic                cfg_shift,
    input  logic                cfg_load,
    output logic                cfg_sdo,
    output logic                cfg_ack,
    output logic                cfg_err,
    input  logic [NUM_PADS-1:0] core_out,
    input  logic [NUM_PADS-1:0] core_oe,
    output logic [NUM_PADS-1:0] core_in,
    input  logic [NUM_PADS-1:0] pad_in,
    output logic [NUM_PADS-1:0] pad_out,
    output logic [NUM_PADS-1:0] pad_oe
);

    localparam int TOTAL = NUM_PADS * CFG_BITS;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TOTAL-1:0] RESET_CHAIN = {NUM_PADS{RESET_MODE}};

    localparam logic [CFG_BITS-1:0] MODE_INPUT  = CFG_BITS'(3'b001);
    localparam logic [CFG_BITS-1:0] MODE_OUTPUT = CFG_BITS'(3'b010);
    localparam logic [CFG_BITS-1:0] MODE_BIDIR  = CFG_BITS'(3'b011);
    localparam logic [CFG_BITS-1:0] MODE_DRIVE0 = CFG_BITS'(3'b100);
    localparam logic [CFG_BITS-1:0] MODE_DRIVE1 = CFG_BITS'(3'b101);

    logic [TOTAL-1:0]    shadow;
    logic [TOTAL-1:0]    active;
    logic [CNT_W-1:0]    count;
    logic [NUM_PADS-1:0] sync1;
    logic [NUM_PADS-1:0] sync2;
    logic [NUM_PADS-1:0] next_out;
    logic [NUM_PADS-1:0] next_oe;
    logic [NUM_PADS-1:0] in_mask;

    assign cfg_sdo = shadow[TOTAL-1];

    // Shift takes priority over load; any evaluated load clears the bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= RESET_CHAIN;
            active  <= RESET_CHAIN;
            count   <= '0;
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
            if (cfg_shift) begin
                shadow <= {shadow[TOTAL-2:0], cfg_sdi};
                if (count != CNT_MAX) begin
                    count <= count + CNT_W'(1);
                end
            end else if (cfg_load) begin
                if (count == CNT_TARGET) begin
                    active  <= shadow;
                    cfg_ack <= 1'b1;
                end else begin
                    cfg_err <= 1'b1;
                end
                count <= '0;
            end
        end
    end

    // Unused codes (000, 110, 111 and anything wider) fall through as disabled.
    always_comb begin
        next_out = '0;
        next_oe  = '0;
        in_mask  = '0;
        for (int k = 0; k < NUM_PADS; k++) begin
            case (active[k*CFG_BITS +: CFG_BITS])
                MODE_INPUT: begin
                    in_mask[k] = 1'b1;
                end
                MODE_OUTPUT: begin
                    next_oe[k]  = 1'b1;
                    next_out[k] = core_out[k];
                end
                MODE_BIDIR: begin
                    next_oe[k]  = core_oe[k];
                    next_out[k] = core_out[k];
                    in_mask[k]  = 1'b1;
                end
                MODE_DRIVE0: begin
                    next_oe[k] = 1'b1;
                end
                MODE_DRIVE1: begin
                    next_oe[k]  = 1'b1;
                    next_out[k] = 1'b1;
                end
                default: begin
                    next_oe[k] = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_out <= '0;
            pad_oe  <= '0;
            sync1   <= '0;
            sync2   <= '0;
        end else begin
            pad_out <= next_out;
            pad_oe  <= next_oe;
            sync1   <= pad_in;
            sync2   <= sync1;
        end
    end

    assign core_in = sync2 & in_mask;

endmodule

// File: tb/tb_pad_cfg_chain.sv
// Directed bench for pad_cfg_chain with NUM_PADS=4: table-driven mode decode
// vectors followed by hand-written load/shift/reset corner sequences.
module tb_pad_cfg_chain;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_sdi;
    logic       cfg_shift;
    logic       cfg_load;
    logic       cfg_sdo;
    logic       cfg_ack;
    logic       cfg_err;
    logic [3:0] core_out;
    logic [3:0] core_oe;
    logic [3:0] core_in;
    logic [3:0] pad_in;
    logic [3:0] pad_out;
    logic [3:0] pad_oe;

    int checks = 0;
    int errors = 0;

    pad_cfg_chain #(
        .NUM_PADS(4),
        .CFG_BITS(3),
        .RESET_MODE(3'b001)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_sdi(cfg_sdi),
        .cfg_shift(cfg_shift),
        .cfg_load(cfg_load),
        .cfg_sdo(cfg_sdo),
        .cfg_ack(cfg_ack),
        .cfg_err(cfg_err),
        .core_out(core_out),
        .core_oe(core_oe),
        .core_in(core_in),
        .pad_in(pad_in),
        .pad_out(pad_out),
        .pad_oe(pad_oe)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] cfg;
        logic [3:0]  co;
        logic [3:0]  coe;
        logic [3:0]  pi;
        logic [3:0]  exp_out;
        logic [3:0]  exp_oe;
        logic [3:0]  exp_ci;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] co, input logic [3:0] coe, input logic [3:0] pi);
        core_out = co;
        core_oe  = coe;
        pad_in   = pi;
    endtask

    // Bits go in MSB first so bits[n-1] ends up at the top of the chain.
    task automatic shift_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            cfg_sdi   = bits[i];
            cfg_shift = 1'b1;
            tick();
        end
        cfg_shift = 1'b0;
        cfg_sdi   = 1'b0;
    endtask

    task automatic do_load(input string name, input logic exp_ack, input logic exp_err);
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        check_output({name, "_ack"}, 16'(cfg_ack), 16'(exp_ack));
        check_output({name, "_err"}, 16'(cfg_err), 16'(exp_err));
    endtask

    initial begin
        vecs[0] = '{12'b101_100_010_011, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1110, 4'b0000};
        vecs[1] = '{12'b101_100_010_011, 4'b1111, 4'b1111, 4'b1111, 4'b1011, 4'b1111, 4'b0001};
        vecs[2] = '{12'b101_100_010_011, 4'b0101, 4'b0000, 4'b1110, 4'b1001, 4'b1110, 4'b0000};
        vecs[3] = '{12'b101_100_010_011, 4'b1010, 4'b0001, 4'b0001, 4'b1010, 4'b1111, 4'b0001};
        vecs[4] = '{12'b000_111_110_001, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0001};
        vecs[5] = '{12'b000_111_110_001, 4'b1111, 4'b1111, 4'b1110, 4'b0000, 4'b0000, 4'b0000};
        vecs[6] = '{12'b011_011_011_011, 4'b1010, 4'b0110, 4'b0101, 4'b1010, 4'b0110, 4'b0101};
        vecs[7] = '{12'b001_000_100_010, 4'b1111, 4'b0000, 4'b1111, 4'b0001, 4'b0011, 4'b1000};
        vecs[8] = '{12'b011_011_011_011, 4'b0101, 4'b1001, 4'b1010, 4'b0101, 4'b1001, 4'b1010};

        rst_n     = 1'b0;
        cfg_sdi   = 1'b0;
        cfg_shift = 1'b0;
        cfg_load  = 1'b0;
        apply_stimulus(4'b0000, 4'b0000, 4'b0000);
        tick();
        tick();
        check_output("rst_pad_oe", 16'(pad_oe), 16'h0);
        check_output("rst_pad_out", 16'(pad_out), 16'h0);
        check_output("rst_core_in", 16'(core_in), 16'h0);
        check_output("rst_ack_err", {14'h0, cfg_ack, cfg_err}, 16'h0);
        check_output("rst_sdo", 16'(cfg_sdo), 16'h0);
        #2;
        rst_n = 1'b1;
        tick();
        check_output("post_rst_pad_oe", 16'(pad_oe), 16'h0);
        check_output("post_rst_ack_err", {14'h0, cfg_ack, cfg_err}, 16'h0);

        // Reset mode is input: pad_in reaches core_in after two edges.
        pad_in = 4'b1010;
        tick();
        check_output("sync_lat1_core_in", 16'(core_in), 16'h0);
        tick();
        check_output("sync_lat2_core_in", 16'(core_in), 16'ha);

        for (int i = 0; i < 9; i++) begin
            apply_stimulus(vecs[i].co, vecs[i].coe, vecs[i].pi);
            if (i == 0 || vecs[i].cfg != vecs[i-1].cfg) begin
                shift_bits(32'(vecs[i].cfg), 12);
                do_load($sformatf("vec%0d_load", i), 1'b1, 1'b0);
            end
            tick();
            check_output($sformatf("vec%0d_pad_out", i), 16'(pad_out), 16'(vecs[i].exp_out));
            check_output($sformatf("vec%0d_pad_oe", i), 16'(pad_oe), 16'(vecs[i].exp_oe));
            tick();
            check_output($sformatf("vec%0d_core_in", i), 16'(core_in), 16'(vecs[i].exp_ci));
        end

        // Short chain rejected, active config kept, counter cleared.
        shift_bits(32'hfff, 11);
        do_load("short11", 1'b0, 1'b1);
        tick();
        check_output("short11_err_pulse", 16'(cfg_err), 16'h0);
        check_output("short11_pad_oe_kept", 16'(pad_oe), 16'h9);
        shift_bits(32'h1, 1);
        do_load("cnt_cleared", 1'b0, 1'b1);

        // Shift and load together on the 12th bit: shift only.
        shift_bits(32'(12'b101_100_010_011 >> 1), 11);
        cfg_sdi   = 1'b1;
        cfg_shift = 1'b1;
        cfg_load  = 1'b1;
        tick();
        cfg_shift = 1'b0;
        check_output("both_hi_ack_err", {14'h0, cfg_ack, cfg_err}, 16'h0);
        do_load("load_after_both", 1'b1, 1'b0);
        tick();
        check_output("both_pad_oe", 16'(pad_oe), 16'hf);
        check_output("both_pad_out", 16'(pad_out), 16'h9);

        // Held load: first cycle accepts, second sees count 0.
        shift_bits(32'(12'b011_011_011_011), 12);
        cfg_load = 1'b1;
        tick();
        check_output("held1_ack_err", {14'h0, cfg_ack, cfg_err}, 16'h2);
        tick();
        cfg_load = 1'b0;
        check_output("held2_ack_err", {14'h0, cfg_ack, cfg_err}, 16'h1);
        tick();
        check_output("held_pad_oe", 16'(pad_oe), 16'h9);

        // Over-long chain: sdo shows first bit after 12 shifts.
        shift_bits(32'h800, 12);
        check_output("sdo_first_bit", 16'(cfg_sdo), 16'h1);
        shift_bits(32'h0, 1);
        check_output("sdo_second_bit", 16'(cfg_sdo), 16'h0);
        do_load("long13", 1'b0, 1'b1);
        tick();
        check_output("long13_pad_oe_kept", 16'(pad_oe), 16'h9);

        // Counter must saturate rather than wrap back to 12.
        shift_bits(32'h0, 28);
        do_load("sat28", 1'b0, 1'b1);

        // Reset in the middle of a shift.
        shift_bits(32'(12'b101_100_010_011), 12);
        do_load("pre_rst_load", 1'b1, 1'b0);
        tick();
        check_output("pre_rst_pad_oe", 16'(pad_oe), 16'hf);
        shift_bits(32'h3f, 6);
        cfg_shift = 1'b1;
        cfg_sdi   = 1'b1;
        rst_n     = 1'b0;
        #1;
        check_output("midrst_pad_oe", 16'(pad_oe), 16'h0);
        check_output("midrst_pad_out", 16'(pad_out), 16'h0);
        check_output("midrst_core_in", 16'(core_in), 16'h0);
        check_output("midrst_sdo", 16'(cfg_sdo), 16'h0);
        tick();
        cfg_shift = 1'b0;
        cfg_sdi   = 1'b0;
        pad_in    = 4'b1111;
        #2;
        rst_n = 1'b1;
        tick();
        check_output("midrst_ack_err", {14'h0, cfg_ack, cfg_err}, 16'h0);
        tick();
        check_output("midrst_mode_in_core_in", 16'(core_in), 16'hf);
        check_output("midrst_mode_in_pad_oe", 16'(pad_oe), 16'h0);
        shift_bits(32'(12'b011_011_011_011), 12);
        do_load("post_rst_load", 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
